phase_unwrap: RTL and testbench

- Sits directly downstream of the 1000-sample moving-average stage and consumes its signed averaged phase samples (26-bit data plus valid).
- Removes 2π discontinuities by tracking sample-to-sample jumps and adding the accumulated multiple of 2π.
- Outputs a continuous, wide signed phase for density conversion, plus the net wrap count and a sticky overflow flag.

---
 rtl/phase_unwrap_pkg.sv | 22 ++
 rtl/phase_unwrap_if.sv | 24 ++
 rtl/phase_unwrap_cmp.sv | 22 ++
 rtl/phase_unwrap.sv | 140 ++++++++++++++
 tb/tb_phase_unwrap.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/phase_unwrap_pkg.sv
// Shared constants and enums for the phase unwrapper: the 2*pi code default,
// the half-turn derivation, the tracking states and the correction direction.
package phase_unwrap_pkg;

    localparam int PHASE_2PI_DEFAULT = 65536;

    function automatic int half_of(input int phase_2pi);
        return phase_2pi / 2;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CORR_NONE = 2'd0,
        CORR_UP   = 2'd1,
        CORR_DOWN = 2'd2
    } corr_t;

endpackage

// File: rtl/phase_unwrap_if.sv
// Sample stream into the unwrapper and the unwrapped phase / wrap status out of it.
// The master modport is the upstream source, the slave modport is the unwrapper.
interface phase_unwrap_if #(
    parameter int C_DATA_WIDTH = 26,
    parameter int C_OUT_WIDTH  = 34,
    parameter int WRAP_WIDTH   = 16
);
    logic signed [C_DATA_WIDTH-1:0] DATA_in;
    logic                           DATA_in_valid;
    logic signed [C_OUT_WIDTH-1:0]  DATA_out;
    logic                           DATA_out_valid;
    logic signed [WRAP_WIDTH-1:0]   wrap_count;
    logic                           overflow;

    modport master (
        output DATA_in, DATA_in_valid,
        input  DATA_out, DATA_out_valid, wrap_count, overflow
    );

    modport slave (
        input  DATA_in, DATA_in_valid,
        output DATA_out, DATA_out_valid, wrap_count, overflow
    );
endinterface

// File: rtl/phase_unwrap_cmp.sv
// Correction decision: a jump of more than half a turn in either direction is a wrap.
// Exactly +/- half a turn is deliberately left uncorrected.
module unwrap_cmp
    import phase_unwrap_pkg::*;
#(
    parameter int C_DATA_WIDTH = 26,
    parameter int PHASE_2PI    = PHASE_2PI_DEFAULT
) (
    input  logic signed [C_DATA_WIDTH:0] diff,
    output corr_t                        corr
);
    localparam logic signed [C_DATA_WIDTH:0] HALF = (C_DATA_WIDTH + 1)'(half_of(PHASE_2PI));

    always_comb begin
        corr = CORR_NONE;
        if (diff > HALF) begin
            corr = CORR_DOWN;
        end else if (diff < -HALF) begin
            corr = CORR_UP;
        end
    end
endmodule

// File: rtl/phase_unwrap.sv
// Two-stage phase unwrapper: stage 1 captures the sample and its jump from the previous
// sample, stage 2 applies the accumulated 2*pi offset and tracks the net wrap count.
//
//   state | meaning
//   IDLE  | no reference sample held; next valid sample is output without correction
//   TRACK | reference held in prev; each valid sample is compared against it
module phase_unwrap
    import phase_unwrap_pkg::*;
#(
    parameter int C_DATA_WIDTH = 26,
    parameter int C_OUT_WIDTH  = 34,
    parameter int PHASE_2PI    = PHASE_2PI_DEFAULT,
    parameter int WRAP_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    phase_unwrap_if.slave  bus
);
    localparam int DW = C_DATA_WIDTH;
    localparam int OW = C_OUT_WIDTH;
    localparam int WW = WRAP_WIDTH;

    state_t                 state;
    logic signed [DW-1:0]   prev;
    logic                   s1_valid;
    logic                   s1_first;
    logic signed [DW-1:0]   s1_sample;
    logic signed [DW:0]     s1_diff;
    logic signed [DW:0]     diff_in;

    logic signed [OW-1:0]   offset;
    logic signed [WW-1:0]   wrap_reg;
    logic signed [OW-1:0]   data_reg;
    logic                   valid_reg;
    logic                   overflow_reg;

    corr_t                  corr;
    logic signed [OW-1:0]   off_base;
    logic signed [WW-1:0]   wrap_base;
    logic signed [OW:0]     off_up;
    logic signed [OW:0]     off_dn;
    logic signed [WW:0]     wrap_up;
    logic signed [WW:0]     wrap_dn;
    logic signed [OW-1:0]   off_next;
    logic signed [WW-1:0]   wrap_next;
    logic                   ovf_hit;

    assign diff_in = {bus.DATA_in[DW-1], bus.DATA_in} - {prev[DW-1], prev};

    // A sample arriving together with clear becomes the fresh reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_sample <= '0;
            s1_diff   <= '0;
        end else begin
            s1_valid <= bus.DATA_in_valid;
            if (bus.DATA_in_valid) begin
                s1_sample <= bus.DATA_in;
                s1_diff   <= diff_in;
                s1_first  <= clear || (state == IDLE);
                prev      <= bus.DATA_in;
                state     <= TRACK;
            end else if (clear) begin
                state <= IDLE;
            end
        end
    end

    unwrap_cmp #(
        .C_DATA_WIDTH (DW),
        .PHASE_2PI    (PHASE_2PI)
    ) u_cmp (
        .diff (s1_diff),
        .corr (corr)
    );

    // Out-of-range steps hold both offset and wrap count so they stay consistent.
    always_comb begin
        off_base  = clear ? '0 : offset;
        wrap_base = clear ? '0 : wrap_reg;
        off_up    = {off_base[OW-1], off_base} + (OW + 1)'(PHASE_2PI);
        off_dn    = {off_base[OW-1], off_base} - (OW + 1)'(PHASE_2PI);
        wrap_up   = {wrap_base[WW-1], wrap_base} + (WW + 1)'(1);
        wrap_dn   = {wrap_base[WW-1], wrap_base} - (WW + 1)'(1);
        off_next  = off_base;
        wrap_next = wrap_base;
        ovf_hit   = 1'b0;
        if (s1_valid && !s1_first) begin
            case (corr)
                CORR_UP: begin
                    if ((off_up[OW] != off_up[OW-1]) || (wrap_up[WW] != wrap_up[WW-1])) begin
                        ovf_hit = 1'b1;
                    end else begin
                        off_next  = off_up[OW-1:0];
                        wrap_next = wrap_up[WW-1:0];
                    end
                end
                CORR_DOWN: begin
                    if ((off_dn[OW] != off_dn[OW-1]) || (wrap_dn[WW] != wrap_dn[WW-1])) begin
                        ovf_hit = 1'b1;
                    end else begin
                        off_next  = off_dn[OW-1:0];
                        wrap_next = wrap_dn[WW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            offset       <= '0;
            wrap_reg     <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            offset    <= off_next;
            wrap_reg  <= wrap_next;
            valid_reg <= s1_valid;
            if (ovf_hit) begin
                overflow_reg <= 1'b1;
            end
            if (s1_valid) begin
                data_reg <= {{(OW - DW){s1_sample[DW-1]}}, s1_sample} + off_next;
            end
        end
    end

    assign bus.DATA_out       = data_reg;
    assign bus.DATA_out_valid = valid_reg;
    assign bus.wrap_count     = wrap_reg;
    assign bus.overflow       = overflow_reg;
endmodule

// File: tb/tb_phase_unwrap.sv
// Directed-vector bench for phase_unwrap with a queue scoreboard; a 4-bit wrap counter
// lets the saturation case be reached with a handful of samples.
module tb_phase_unwrap;
    localparam int DW = 26;
    localparam int OW = 34;
    localparam int WW = 4;

    typedef struct {
        longint data;
        int     wrap;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    phase_unwrap_if #(.C_DATA_WIDTH(DW), .C_OUT_WIDTH(OW), .WRAP_WIDTH(WW)) bus ();

    phase_unwrap #(
        .C_DATA_WIDTH (DW),
        .C_OUT_WIDTH  (OW),
        .PHASE_2PI    (65536),
        .WRAP_WIDTH   (WW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(input int v, input longint ed, input int ew, input bit eo, input bit clr);
        exp_t e;
        @(posedge clk);
        #1;
        bus.DATA_in       = v[DW-1:0];
        bus.DATA_in_valid = 1'b1;
        clear             = clr;
        e.data = ed;
        e.wrap = ew;
        e.ovf  = eo;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.DATA_in_valid = 1'b0;
            clear             = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        bus.DATA_in_valid = 1'b0;
        clear             = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("wrap_after_clear", longint'(bus.wrap_count), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.DATA_out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got data %0d with empty scoreboard",
                         longint'(bus.DATA_out));
            end else begin
                e = exp_q.pop_front();
                if (longint'(bus.DATA_out) !== e.data || int'(bus.wrap_count) !== e.wrap
                    || bus.overflow !== e.ovf) begin
                    failures++;
                    $display("FAIL sample_out: got data=%0d wrap=%0d ovf=%0b expected data=%0d wrap=%0d ovf=%0b",
                             longint'(bus.DATA_out), int'(bus.wrap_count), bus.overflow,
                             e.data, e.wrap, e.ovf);
                end
            end
        end
    end

    initial begin
        int samp;
        int drain;
        bus.DATA_in       = '0;
        bus.DATA_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", longint'(bus.DATA_out), 0);
        check("reset_valid", longint'(bus.DATA_out_valid), 0);
        check("reset_wrap", longint'(bus.wrap_count), 0);
        check("reset_ovf", longint'(bus.overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ramp, then an upward wrap and a follow-on sample
        send(0, 0, 0, 0, 0);
        send(10000, 10000, 0, 0, 0);
        send(20000, 20000, 0, 0, 0);
        send(30000, 30000, 0, 0, 0);
        send(-30000, 35536, 1, 0, 0);
        send(-20000, 45536, 1, 0, 0);
        idle(3);
        check("wrap_hold", longint'(bus.wrap_count), 1);
        do_clear();

        // downward wrap
        send(-30000, -30000, 0, 0, 0);
        send(30000, -35536, -1, 0, 0);
        idle(3);
        do_clear();

        // exactly half a turn is not corrected; one code past it is
        send(0, 0, 0, 0, 0);
        send(32768, 32768, 0, 0, 0);
        send(32768, 32768, 0, 0, 0);
        send(-1, 65535, 1, 0, 0);
        idle(3);

        // clear coinciding with a valid sample makes it the new reference
        send(500, 500, 0, 0, 1);
        send(600, 600, 0, 0, 0);
        idle(3);

        // eight upward wraps saturate a 4-bit counter at 7
        for (int k = 1; k <= 8; k++) begin
            samp = 600 - 40000 * k;
            send(samp, longint'(samp) + longint'((k < 7) ? k : 7) * 65536,
                 (k < 7) ? k : 7, (k == 8), 0);
        end
        idle(3);
        check("ovf_set", longint'(bus.overflow), 1);
        do_clear();
        check("ovf_sticky_clear", longint'(bus.overflow), 1);
        send(100, 100, 0, 1, 0);
        idle(3);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ovf", longint'(bus.overflow), 0);
        check("rst_wrap", longint'(bus.wrap_count), 0);
        check("rst_data", longint'(bus.DATA_out), 0);

        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        check("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
